// File: rtl/alu_share_arbiter_if.sv
// Bundles the two request ports, the ALU drive/return pair and the shared
// response channel between the arbiter and its surroundings.
interface alu_share_arbiter_if #(parameter int WIDTH = 64);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [WIDTH-1:0] alu_x, alu_y, alu_result;
  logic [3:0]       alu_ctrl;
  logic             alu_zero;
  logic             resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [WIDTH-1:0] resp_result;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_x, req0_y, req1_x, req1_y,
           alu_result, alu_zero, resp_ready,
    input  req0_ready, req1_ready, alu_x, alu_y, alu_ctrl,
           resp_valid, resp_id, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_x, req0_y, req1_x, req1_y,
           alu_result, alu_zero, resp_ready,
    output req0_ready, req1_ready, alu_x, alu_y, alu_ctrl,
           resp_valid, resp_id, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters:
// grant -> drive ALU for one cycle -> hold tagged response until consumed.
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t           r_state;
  logic             r_last_grant, r_grant_id;
  logic [WIDTH-1:0] r_alu_x, r_alu_y, r_resp_result;
  logic [3:0]       r_alu_ctrl;
  logic             r_resp_valid, r_resp_id, r_resp_zero, r_resp_err;

  logic w_idle, w_gnt0, w_gnt1, w_legal;

  // On a tie the requester that did not win last time goes next.
  assign w_idle = (r_state == S_IDLE);
  assign w_gnt0 = w_idle && bus.req0_valid && (!bus.req1_valid ||  r_last_grant);
  assign w_gnt1 = w_idle && bus.req1_valid && (!bus.req0_valid || !r_last_grant);

  always_comb begin
    w_legal = 1'b0;
    case (r_alu_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_grant_id    <= 1'b0;
      r_alu_x       <= '0;
      r_alu_y       <= '0;
      r_alu_ctrl    <= 4'b0000;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0) begin
            r_alu_x      <= bus.req0_x;
            r_alu_y      <= bus.req0_y;
            r_alu_ctrl   <= bus.req0_op;
            r_grant_id   <= 1'b0;
            r_last_grant <= 1'b0;
            r_state      <= S_EXEC;
          end else if (w_gnt1) begin
            r_alu_x      <= bus.req1_x;
            r_alu_y      <= bus.req1_y;
            r_alu_ctrl   <= bus.req1_op;
            r_grant_id   <= 1'b1;
            r_last_grant <= 1'b1;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Illegal codes report an error with a cleared result and flag.
          r_resp_result <= w_legal ? bus.alu_result : '0;
          r_resp_zero   <= w_legal && bus.alu_zero;
          r_resp_err    <= !w_legal;
          r_resp_id     <= r_grant_id;
          r_resp_valid  <= 1'b1;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = w_gnt0;
  assign bus.req1_ready  = w_gnt1;
  assign bus.alu_x       = r_alu_x;
  assign bus.alu_y       = r_alu_y;
  assign bus.alu_ctrl    = r_alu_ctrl;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_id     = r_resp_id;
  assign bus.resp_result = r_resp_result;
  assign bus.resp_zero   = r_resp_zero;
  assign bus.resp_err    = r_resp_err;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives directed and random traffic into alu_share_arbiter with a stub ALU
// and compares every cycle against a transaction-level model of the rules.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_share_arbiter_if #(.WIDTH(64)) bus();

  alu_share_arbiter #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Stub ALU; illegal codes produce ~x so the arbiter's forcing is visible.
  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      default: return ~x;
    endcase
  endfunction

  always_comb begin
    bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_x, bus.alu_y);
    bus.alu_zero   = (bus.alu_result == 64'd0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: at most one operation in flight, described by its age.
  bit          m_free  = 1'b1;
  bit          m_exec  = 1'b0;
  bit          m_resp  = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_clean = 1'b1;
  bit          m_id;
  logic [3:0]  m_op;
  logic [63:0] m_x, m_y;

  task automatic step(input bit v0, input bit v1,
                      input logic [3:0] o0, input logic [63:0] x0, input logic [63:0] y0,
                      input logic [3:0] o1, input logic [63:0] x1, input logic [63:0] y1,
                      input bit rr, input bit rs);
    bit e0, e1, legal;
    logic [63:0] raw;
    @(posedge clk); #1;
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_x = x0; bus.req0_y = y0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_x = x1; bus.req1_y = y1;
    bus.resp_ready = rr; rst = rs;
    #1;
    e0 = m_free && v0 && (!v1 ||  m_last);
    e1 = m_free && v1 && (!v0 || !m_last);
    chk("req0_ready", {63'd0, bus.req0_ready}, {63'd0, e0});
    chk("req1_ready", {63'd0, bus.req1_ready}, {63'd0, e1});
    chk("resp_valid", {63'd0, bus.resp_valid}, {63'd0, m_resp});
    if (m_exec || m_resp) begin
      chk("alu_x",    bus.alu_x, m_x);
      chk("alu_y",    bus.alu_y, m_y);
      chk("alu_ctrl", {60'd0, bus.alu_ctrl}, {60'd0, m_op});
    end
    if (m_resp) begin
      legal = (m_op == 4'd0) || (m_op == 4'd1) || (m_op == 4'd2) || (m_op == 4'd6);
      raw   = alu_fn(m_op, m_x, m_y);
      chk("resp_id",     {63'd0, bus.resp_id},   {63'd0, m_id});
      chk("resp_result", bus.resp_result,        legal ? raw : 64'd0);
      chk("resp_zero",   {63'd0, bus.resp_zero}, {63'd0, legal && (raw == 64'd0)});
      chk("resp_err",    {63'd0, bus.resp_err},  {63'd0, !legal});
    end
    if (m_clean) begin
      chk("rst_alu_x",    bus.alu_x, 64'd0);
      chk("rst_alu_y",    bus.alu_y, 64'd0);
      chk("rst_alu_ctrl", {60'd0, bus.alu_ctrl}, 64'd0);
      chk("rst_resp",     {bus.resp_result[61:0], bus.resp_id, bus.resp_zero | bus.resp_err}, 64'd0);
      m_clean = 1'b0;
    end
    if (rs) begin
      m_free = 1'b1; m_exec = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_clean = 1'b1;
    end else begin
      if (m_resp && rr) begin m_resp = 1'b0; m_free = 1'b1; end
      if (m_exec) begin m_exec = 1'b0; m_resp = 1'b1; end
      if (e0 || e1) begin
        m_free = 1'b0; m_exec = 1'b1; m_last = e1; m_id = e1;
        m_op = e1 ? o1 : o0;
        m_x  = e1 ? x1 : x0;
        m_y  = e1 ? y1 : y0;
      end
    end
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rr, 0);
  endtask

  function automatic logic [3:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0110;
      default: return 4'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 64'd0;
      1: return 64'($urandom_range(0, 15));
      2: return {64{1'b1}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] a0, b0, a1, b1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.resp_ready = 0;
    bus.req0_op = 0; bus.req1_op = 0;
    bus.req0_x = 0; bus.req0_y = 0; bus.req1_x = 0; bus.req1_y = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2, 1);
    // single ADD 5+3
    step(1, 0, 4'b0010, 64'd5, 64'd3, 0, 0, 0, 1, 0);
    idle(4, 1);
    // tie and alternation: AND vs OR
    for (int i = 0; i < 12; i++)
      step(1, 1, 4'b0000, 64'hF0, 64'h3C, 4'b0001, 64'hF0, 64'h0F, 1, 0);
    idle(3, 1);
    // SUB to zero, SUB wrap
    step(0, 1, 0, 0, 0, 4'b0110, 64'd7, 64'd7, 1, 0);
    idle(3, 1);
    step(1, 0, 4'b0110, 64'd0, 64'd1, 0, 0, 0, 1, 0);
    idle(3, 1);
    // backpressure with req1 waiting
    step(1, 0, 4'b0010, 64'd10, 64'd20, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 4'b0001, 64'hA, 64'h5, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 4'b0001, 64'hA, 64'h5, 1, 0);
    idle(3, 1);
    // illegal op
    step(1, 0, 4'b0111, 64'd1, 64'd1, 0, 0, 0, 1, 0);
    idle(4, 1);
    // reset during EXEC, then confirm the aborted op never shows
    step(0, 1, 0, 0, 0, 4'b0010, 64'd1, 64'd2, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(4, 1);
    step(1, 1, 4'b0010, 64'd1, 64'd1, 4'b0010, 64'd2, 64'd2, 1, 0);
    idle(3, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      a0 = rnd_val(); a1 = rnd_val();
      b0 = ($urandom_range(0, 3) == 0) ? a0 : rnd_val();
      b1 = ($urandom_range(0, 3) == 0) ? a1 : rnd_val();
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
           rnd_op(), a0, b0, rnd_op(), a1, b1,
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    idle(4, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
